// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch/execute sequencer
// of the 8-bit accumulator core.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_OP,
    FETCH_ARG,
    EXEC
  } state_t;

  localparam logic [7:0] OP_JMP = 8'h0A;
  localparam logic [7:0] OP_CLL = 8'h0C;
  localparam logic [7:0] OP_RET = 8'h0D;
  localparam logic [7:0] OP_NOP = 8'h11;

  localparam logic [7:0] NOP_OPCODE = OP_NOP;

  // decoder stack request encoding {PUSH, POP}
  localparam logic [1:0] STK_PUSH = 2'b10;
  localparam logic [1:0] STK_POP  = 2'b01;

endpackage

// File: rtl/fetch_seq_pc_unit.sv
// Program counter register: clear beats load,
// load beats increment; arithmetic wraps.
module pc_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)       pc <= '0;
    else if (clr)  pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + W'(1);
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch/execute sequencer: two-byte fetch over req/ack,
// one-cycle execute strobe and return-stack control.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int         PC_WIDTH   = 8,
  parameter logic [7:0] NOP_OPCODE = fetch_seq_pkg::NOP_OPCODE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic                pm_req,
  input  logic                pm_ack,
  input  logic [7:0]          pm_data,
  output logic [7:0]          instr,
  output logic [7:0]          operand,
  input  logic                id_jmp_en,
  input  logic [1:0]          id_stack_control,
  input  logic                id_rst,
  output logic                exec_en,
  output logic [PC_WIDTH-1:0] stack_din,
  input  logic [PC_WIDTH-1:0] stack_dout,
  output logic                stack_push,
  output logic                stack_pop,
  output logic                stack_err,
  output logic                busy
);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] load_val;
  logic                pc_clr;
  logic                pc_load;
  logic                pc_inc;
  logic                fetching;

  pc_unit #(.W(PC_WIDTH)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .clr      (pc_clr),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (load_val),
    .pc       (pc)
  );

  assign fetching  = (state == FETCH_OP) || (state == FETCH_ARG);
  assign pm_req    = fetching;
  assign pm_addr   = pc;
  assign busy      = (state != IDLE);
  assign exec_en   = (state == EXEC);
  // pc already points past the operand while in EXEC
  assign stack_din = pc;

  always_comb begin
    pc_clr     = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = fetching && pm_ack;
    load_val   = '0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    stack_err  = 1'b0;
    if (exec_en) begin
      if (id_rst) begin
        pc_clr = 1'b1;
      end else if (instr == OP_CLL) begin
        if (id_stack_control == STK_PUSH) begin
          stack_push = 1'b1;
          pc_load    = 1'b1;
          load_val   = PC_WIDTH'(operand);
        end else begin
          stack_err = 1'b1;
        end
      end else if (instr == OP_RET) begin
        if (id_stack_control == STK_POP) begin
          stack_pop = 1'b1;
          pc_load   = 1'b1;
          load_val  = stack_dout;
        end else begin
          stack_err = 1'b1;
        end
      end else if (id_jmp_en) begin
        pc_load  = 1'b1;
        load_val = PC_WIDTH'(operand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr   <= NOP_OPCODE;
      operand <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) state <= FETCH_OP;
        end
        FETCH_OP: begin
          if (pm_ack) begin
            instr <= pm_data;
            state <= FETCH_ARG;
          end
        end
        FETCH_ARG: begin
          if (pm_ack) begin
            operand <= pm_data;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (id_rst) begin
            instr <= NOP_OPCODE;
            state <= IDLE;
          end else begin
            state <= run ? FETCH_OP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq with an
// instruction-level reference model.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] pm_addr;
  logic       pm_req;
  logic       pm_ack;
  logic [7:0] pm_data;
  logic [7:0] instr;
  logic [7:0] operand;
  logic       id_jmp_en;
  logic [1:0] id_stack_control;
  logic       id_rst;
  logic       exec_en;
  logic [7:0] stack_din;
  logic [7:0] stack_dout;
  logic       stack_push;
  logic       stack_pop;
  logic       stack_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_pc;
  logic [7:0] exp_instr;
  logic [7:0] exp_operand;

  always #5 clk = ~clk;

  fetch_seq #(.PC_WIDTH(8), .NOP_OPCODE(8'h11)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .pm_addr          (pm_addr),
    .pm_req           (pm_req),
    .pm_ack           (pm_ack),
    .pm_data          (pm_data),
    .instr            (instr),
    .operand          (operand),
    .id_jmp_en        (id_jmp_en),
    .id_stack_control (id_stack_control),
    .id_rst           (id_rst),
    .exec_en          (exec_en),
    .stack_din        (stack_din),
    .stack_dout       (stack_dout),
    .stack_push       (stack_push),
    .stack_pop        (stack_pop),
    .stack_err        (stack_err),
    .busy             (busy)
  );

  task automatic fill_mem();
    logic [7:0] pick [5];
    pick[0] = 8'h09; pick[1] = OP_JMP; pick[2] = OP_CLL;
    pick[3] = OP_RET; pick[4] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      int k;
      k = $urandom_range(0, 4);
      mem[i] = (k == 4) ? 8'($urandom) : pick[k];
    end
  endtask

  // Walks one instruction from FETCH_OP through EXEC.
  task automatic do_instr(input int dop, input int darg,
                          input logic jmp, input logic [1:0] sc,
                          input logic irst, input logic [7:0] sdout,
                          input logic run_next);
    logic [7:0] npc;
    logic ep, eo, ee;
    for (int i = 0; i <= dop; i++) begin
      @(negedge clk);
      pm_ack = (i == dop);
      pm_data = mem[exp_pc];
      id_jmp_en = 1'($urandom);
      id_stack_control = 2'($urandom);
      run = 1'($urandom);
      #1;
      checks++;
      if ({pm_req, pm_addr, exec_en, busy, stack_push, stack_pop, stack_err}
          !== {1'b1, exp_pc, 1'b0, 1'b1, 3'b000}) begin
        errors++;
        $display("FAIL fetch_op: req=%b addr=%h exec=%b busy=%b stk=%b%b%b want req=1 addr=%h exec=0 busy=1 stk=000",
                 pm_req, pm_addr, exec_en, busy, stack_push, stack_pop,
                 stack_err, exp_pc);
      end
    end
    exp_instr = mem[exp_pc];
    exp_pc++;
    for (int i = 0; i <= darg; i++) begin
      @(negedge clk);
      pm_ack = (i == darg);
      pm_data = mem[exp_pc];
      run = 1'($urandom);
      #1;
      checks++;
      if ({pm_req, pm_addr, exec_en, busy, instr}
          !== {1'b1, exp_pc, 1'b0, 1'b1, exp_instr}) begin
        errors++;
        $display("FAIL fetch_arg: req=%b addr=%h exec=%b busy=%b instr=%h want req=1 addr=%h exec=0 busy=1 instr=%h",
                 pm_req, pm_addr, exec_en, busy, instr, exp_pc, exp_instr);
      end
    end
    exp_operand = mem[exp_pc];
    exp_pc++;
    @(negedge clk);
    pm_ack = 1'($urandom);
    pm_data = 8'($urandom);
    id_jmp_en = jmp;
    id_stack_control = sc;
    id_rst = irst;
    stack_dout = sdout;
    run = run_next;
    #1;
    ep = 1'b0; eo = 1'b0; ee = 1'b0;
    npc = exp_pc;
    if (irst) npc = 8'h00;
    else if (exp_instr == OP_CLL) begin
      if (sc == 2'b10) begin ep = 1'b1; npc = exp_operand; end
      else ee = 1'b1;
    end else if (exp_instr == OP_RET) begin
      if (sc == 2'b01) begin eo = 1'b1; npc = sdout; end
      else ee = 1'b1;
    end else if (jmp) npc = exp_operand;
    checks++;
    if ({exec_en, stack_push, stack_pop, stack_err, pm_req, busy, instr, operand}
        !== {1'b1, ep, eo, ee, 1'b0, 1'b1, exp_instr, exp_operand}) begin
      errors++;
      $display("FAIL exec: exec=%b push=%b pop=%b err=%b req=%b busy=%b instr=%h opnd=%h want 1 %b %b %b 0 1 %h %h",
               exec_en, stack_push, stack_pop, stack_err, pm_req, busy,
               instr, operand, ep, eo, ee, exp_instr, exp_operand);
    end
    if (ep) begin
      checks++;
      if (stack_din !== exp_pc) begin
        errors++;
        $display("FAIL stack_din: got %h want %h", stack_din, exp_pc);
      end
    end
    exp_pc = npc;
    if (irst) exp_instr = 8'h11;
    @(posedge clk);
    #1;
    id_jmp_en = 1'b0;
    id_stack_control = 2'b00;
    id_rst = 1'b0;
    pm_ack = 1'b0;
  endtask

  // DUT must be parked; stays idle n cycles, then starts fetching.
  task automatic go_from_idle(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      run = (i == n);
      pm_ack = 1'($urandom);
      pm_data = 8'($urandom);
      #1;
      checks++;
      if ({busy, pm_req, exec_en, pm_addr, instr, stack_push, stack_pop, stack_err}
          !== {3'b000, exp_pc, exp_instr, 3'b000}) begin
        errors++;
        $display("FAIL idle: busy=%b req=%b exec=%b addr=%h instr=%h stk=%b%b%b want 0 0 0 %h %h 000",
                 busy, pm_req, exec_en, pm_addr, instr, stack_push,
                 stack_pop, stack_err, exp_pc, exp_instr);
      end
    end
    @(posedge clk);
    #1;
    pm_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; pm_ack = 1'b1; pm_data = 8'hA5;
    id_jmp_en = 1'b0; id_stack_control = 2'b00; id_rst = 1'b0;
    stack_dout = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; pm_ack = 1'b0;
    #1;
    exp_pc = 8'h00; exp_instr = 8'h11; exp_operand = 8'h00;
    checks++;
    if ({pm_req, pm_addr, instr, operand, exec_en, stack_push, stack_pop, stack_err, busy}
        !== {1'b0, 8'h00, 8'h11, 8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL reset: req=%b addr=%h instr=%h opnd=%h exec=%b stk=%b%b%b busy=%b",
               pm_req, pm_addr, instr, operand, exec_en, stack_push,
               stack_pop, stack_err, busy);
    end
  endtask

  task automatic test_basic();
    test_reset();
    mem[8'h00] = 8'h09; mem[8'h01] = 8'h00;
    go_from_idle(1);
    do_instr(0, 0, 1'b0, 2'b00, 1'b0, 8'h33, 1'b0);
    go_from_idle(1);
  endtask

  task automatic test_jmp();
    test_reset();
    mem[8'h00] = OP_JMP; mem[8'h01] = 8'h40;
    mem[8'h40] = 8'h09;
    go_from_idle(0);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    do_instr(0, 0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_call_ret();
    test_reset();
    mem[8'h00] = OP_JMP; mem[8'h01] = 8'h10;
    mem[8'h10] = OP_CLL; mem[8'h11] = 8'h80;
    mem[8'h80] = OP_RET;
    mem[8'h12] = 8'h09;
    go_from_idle(0);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    do_instr(0, 0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
    do_instr(1, 0, 1'b0, 2'b01, 1'b0, 8'h12, 1'b1);
    do_instr(0, 1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    go_from_idle(0);
  endtask

  task automatic test_stack_err();
    test_reset();
    mem[8'h00] = OP_JMP; mem[8'h01] = 8'h80;
    mem[8'h80] = OP_RET; mem[8'h82] = OP_CLL; mem[8'h83] = 8'h55;
    mem[8'h84] = OP_CLL; mem[8'h85] = 8'h66;
    go_from_idle(0);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h44, 1'b1);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    do_instr(0, 0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0);
    go_from_idle(0);
  endtask

  task automatic test_delayed_ack();
    test_reset();
    mem[8'h00] = 8'h09; mem[8'h01] = 8'h77;
    go_from_idle(0);
    do_instr(1, 3, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    go_from_idle(0);
  endtask

  task automatic test_wrap();
    test_reset();
    mem[8'h00] = OP_JMP; mem[8'h01] = 8'hFE;
    mem[8'hFE] = 8'h09; mem[8'hFF] = 8'h01;
    go_from_idle(0);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    do_instr(0, 0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    go_from_idle(0);
  endtask

  task automatic test_rst_mid();
    test_reset();
    mem[8'h00] = OP_JMP; mem[8'h01] = 8'h20;
    mem[8'h20] = 8'h09;
    go_from_idle(0);
    do_instr(0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    pm_ack = 1'b0; rst = 1'b1; run = 1'b1;
    @(negedge clk);
    rst = 1'b0; pm_ack = 1'b1; pm_data = 8'hEE;
    #1;
    checks++;
    if ({pm_req, pm_addr, instr, operand, busy, exec_en}
        !== {1'b0, 8'h00, 8'h11, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL rst_mid: req=%b addr=%h instr=%h opnd=%h busy=%b exec=%b want 0 00 11 00 0 0",
               pm_req, pm_addr, instr, operand, busy, exec_en);
    end
    @(negedge clk);
    pm_ack = 1'b0;
    #1;
    checks++;
    if ({pm_req, pm_addr, instr} !== {1'b1, 8'h00, 8'h11}) begin
      errors++;
      $display("FAIL rst_late_ack: req=%b addr=%h instr=%h want 1 00 11",
               pm_req, pm_addr, instr);
    end
    exp_pc = 8'h00; exp_instr = 8'h11; exp_operand = 8'h00;
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    test_reset();
    fill_mem();
    go_from_idle(0);
    for (int n = 0; n < 300; n++) begin
      logic irst, rn;
      irst = ($urandom_range(0, 15) == 0);
      rn   = ($urandom_range(0, 7) != 0);
      do_instr($urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom), 2'($urandom), irst, 8'($urandom), rn);
      if (irst || !rn) go_from_idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_basic();
    test_jmp();
    test_call_ret();
    test_stack_err();
    test_delayed_ack();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch/execute sequencer for the 8-bit accumulator core. It owns the program counter and fetches two-byte instructions (opcode, operand) from program memory through a req/ack handshake. It presents the latched opcode to the instruction decoder and consumes the decoder's jump, stack and reset requests. It issues a one-cycle execute strobe that qualifies all register-file, accumulator and data-memory writes, and it drives the return-address stack.

## Interface
Parameters:
- PC_WIDTH, 8, program counter and program memory address width
- NOP_OPCODE, 8'h11, value loaded into `instr` at reset

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  when low, sequencer parks in IDLE at the next instruction boundary
- pm_addr  out  PC_WIDTH  program memory address
- pm_req  out  1  program memory read request
- pm_ack  in  1  read data valid this cycle
- pm_data  in  8  program memory read data
- instr  out  8  latched opcode, feeds decoder `instr`
- operand  out  8  latched second byte (jump target, immediate, register address)
- id_jmp_en  in  1  decoder jump request
- id_stack_control  in  2  decoder {PUSH, POP}
- id_rst  in  1  decoder soft-reset request
- exec_en  out  1  one-cycle execute strobe
- stack_din  out  PC_WIDTH  return address to push
- stack_dout  in  PC_WIDTH  top of stack (combinational)
- stack_push, stack_pop  out  1  one-cycle stack strobes
- stack_err  out  1  one-cycle pulse: CLL on full stack or RET on empty stack
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH_OP, FETCH_ARG, EXEC.
- IDLE: transition to FETCH_OP when run=1.
- FETCH_OP: pm_req=1, pm_addr=pc. On pm_ack: instr<=pm_data, pc<=pc+1, transition to FETCH_ARG.
- FETCH_ARG: same handshake. On pm_ack: operand<=pm_data, pc<=pc+1, transition to EXEC.
- EXEC lasts exactly one cycle with exec_en=1. PC update, in priority order:
  - id_rst: pc<=0, instr<=NOP_OPCODE, transition to IDLE. No stack strobes.
  - instr==CLL (8'h0C): if id_stack_control==10, then stack_push=1, stack_din=pc (address of the next instruction), pc<=operand. Otherwise stack_err=1 and pc is unchanged.
  - instr==RET (8'h0D): if id_stack_control==01, then stack_pop=1, pc<=stack_dout. Otherwise stack_err=1 and pc is unchanged.
  - id_jmp_en (JMP, JMA taken): pc<=operand.
  - Otherwise pc is unchanged, having already advanced by 2.
- EXEC exit (when not id_rst): FETCH_OP if run=1, else IDLE.
- PC arithmetic is modulo 2^PC_WIDTH. 0xFF+1 wraps to 0x00 with no flag.
- Reset values: pc=0, pm_req=0, instr=NOP_OPCODE, operand=0, exec_en=0, stack_push=0, stack_pop=0, stack_err=0, busy=0, state=IDLE.

## Timing
- pm_req stays high and pm_addr stays stable until pm_ack is sampled high. pm_data is sampled on the ack cycle only.
- pm_ack is legal in the same cycle as pm_req, giving a minimum of 3 cycles per instruction.
- exec_en, stack_push, stack_pop and stack_err are combinational decodes of the EXEC state and inputs, so each is high for exactly one cycle.
- stack_dout is sampled in the EXEC cycle. The pop takes effect after that edge.
- The next pm_addr reflects the EXEC result one cycle after EXEC.
- pm_ack outside FETCH_OP/FETCH_ARG is ignored.
- rst mid-handshake: the next cycle has pm_req=0 and all reset values. Any late pm_ack is ignored.
- run falling mid-instruction: the instruction completes, then the sequencer enters IDLE.

## Structure
- Shared package: state enum (IDLE, FETCH_OP, FETCH_ARG, EXEC), CLL and RET opcode constants alongside the existing instruction definitions, and NOP_OPCODE.
- One sub-module, `pc_unit`: PC register with an increment, load and clear interface. The FSM and strobe decode stay in fetch_seq.

## Test plan
- Reset, then run=1, ack same cycle, program {0x09,0x00}: pm_addr 0x00 then 0x01, exec_en at cycle 3, next pm_addr 0x02.
- JMP: {0x0A,0x40} at 0x00: exec_en pulses, next pm_addr 0x40.
- Call/return: CLL 0x80 at 0x10 with stack_flags not full → stack_push with stack_din=0x12, fetch from 0x80. RET at 0x80 with stack_dout=0x12 → stack_pop, fetch from 0x12.
- RET with empty stack (id_stack_control=00): stack_err pulses, no pop, fetch continues at 0x82. CLL on full stack: stack_err, no push, pc+2.
- pm_ack delayed 3 cycles in FETCH_ARG: pm_req held, pm_addr stable, no exec_en until ack plus 1.
- Instruction at 0xFE: next fetch at 0x00. rst asserted during FETCH_OP wait: pm_req=0, instr=0x11, pc=0 on the next cycle.
